// File: rtl/param_seq_det.sv
// param_seq_det -- runtime-programmable serial pattern detector.
//
// Watches a serial stream qualified by serValid and pulses w for one cycle
// in the cycle after the bit that completes the programmed pattern.
// Pattern and length are loaded at reset from DEF_PAT/DEF_LEN, or at runtime
// through a one-cycle cfg_load strobe.
//
// Optional feature: define PARAM_SEQ_DET_MATCH_CNT_EN to add the saturating
// match counter and its match_cnt output port.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   serIn     serial data bit
//   serValid  serIn qualifier
//   overlap   1 = overlapping matches, 0 = history cleared after a match
//   cfg_load  strobe: load cfg_pat / cfg_len, clear history
//   cfg_pat   pattern, first-received bit at cfg_pat[len-1], last at [0]
//   cfg_len   pattern length, 0 -> 1, >PAT_W -> PAT_W
//   w         registered one-cycle match pulse
//   match_cnt saturating match count (optional)
module param_seq_det #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 8'b0011_1110,
  parameter int               DEF_LEN = 7,
  parameter int               CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serIn,
  input  logic                       serValid,
  input  logic                       overlap,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pat,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
  output logic [CNT_W-1:0]           match_cnt,
`endif
  output logic                       w
);

  localparam int               LEN_W    = $clog2(PAT_W+1);
  localparam logic [PAT_W-1:0] ALL_ONES = '1;

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  logic [PAT_W-1:0] nh;
  logic [LEN_W-1:0] nf;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] cfg_len_c;
  logic             hit;

  always_comb begin
    nh   = {hist[PAT_W-2:0], serIn};
    // fill saturates at PAT_W; guard the increment so it never wraps
    nf   = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    // low len_reg bits set; a shift by PAT_W yields all ones
    mask = ~(ALL_ONES << len_reg);
    hit  = (nf >= len_reg) && ((nh & mask) == (pat_reg & mask));
    if (cfg_len == '0)
      cfg_len_c = LEN_W'(1);
    else if (cfg_len > LEN_W'(PAT_W))
      cfg_len_c = LEN_W'(PAT_W);
    else
      cfg_len_c = cfg_len;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_reg <= DEF_PAT;
      len_reg <= LEN_W'(DEF_LEN);
      hist    <= '0;
      fill    <= '0;
      w       <= 1'b0;
    end else if (cfg_load) begin
      pat_reg <= cfg_pat;
      len_reg <= cfg_len_c;
      hist    <= '0;
      fill    <= '0;
      w       <= 1'b0;
    end else if (serValid) begin
      hist <= nh;
      w    <= hit;
      fill <= (hit && !overlap) ? '0 : nf;
    end else begin
      w <= 1'b0;
    end
  end

`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst || cfg_load)
      match_cnt <= '0;
    else if (serValid && hit && (match_cnt != '1))
      match_cnt <= match_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_param_seq_det.sv
module tb_param_seq_det;

  localparam int PAT_W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       overlap = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       w;
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
  logic [1:0] match_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_seq_det #(.CNT_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .serIn(ser_in),
    .serValid(ser_valid),
    .overlap(overlap),
    .cfg_load(cfg_load),
    .cfg_pat(cfg_pat),
    .cfg_len(cfg_len),
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
    .match_cnt(match_cnt),
`endif
    .w(w)
  );

  // reference model: queue of bits seen since the last clear
  bit       mq[$];
  bit [7:0] m_pat;
  int       m_len;
  int       m_cnt;
  bit       m_w;

  function automatic void model_step(bit r, bit ld, bit [7:0] p, int l,
                                     bit v, bit b, bit ov);
    bit h;
    if (!r) begin
      mq.delete(); m_pat = 8'b0011_1110; m_len = 7; m_w = 0; m_cnt = 0;
    end else if (ld) begin
      m_pat = p;
      m_len = (l == 0) ? 1 : (l > PAT_W ? PAT_W : l);
      mq.delete(); m_w = 0; m_cnt = 0;
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      h = (mq.size() >= m_len);
      for (int i = 0; i < m_len; i++)
        if (h && mq[mq.size()-1-i] != m_pat[i]) h = 0;
      m_w = h;
      if (h && m_cnt < 3) m_cnt++;
      if (h && !ov) mq.delete();
    end else begin
      m_w = 0;
    end
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // apply one cycle of inputs; outputs sampled 1 time unit after the edge
  task automatic step(bit r, bit ld, bit [7:0] p, bit [3:0] l,
                      bit v, bit b, bit ov);
    rst = r; cfg_load = ld; cfg_pat = p; cfg_len = l;
    ser_valid = v; ser_in = b; overlap = ov;
    @(posedge clk);
    #1;
    model_step(r, ld, p, int'(l), v, b, ov);
  endtask

  typedef struct {
    bit       r;
    bit       ld;
    bit [7:0] pat;
    bit [3:0] len;
    bit       v;
    bit       b;
    bit       ov;
    bit       ew;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit ld, bit [7:0] p, bit [3:0] l,
                              bit v, bit b, bit ov, bit ew);
    vec_t t;
    t.r = r; t.ld = ld; t.pat = p; t.len = l;
    t.v = v; t.b = b; t.ov = ov; t.ew = ew;
    return t;
  endfunction

  function automatic void add_bits(bit [15:0] bits, int n, bit ov, int hit_mask);
    for (int i = n - 1; i >= 0; i--)
      vecs.push_back(mk(1, 0, 0, 0, 1, bits[i], ov, hit_mask[i]));
  endfunction

  initial begin
    // reset defaults, then 0111110
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    add_bits(16'b0111110, 7, 0, 'b0000001);
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    // overlap = 1 on 101 / 10101
    vecs.push_back(mk(1, 1, 8'b101, 3, 0, 0, 1, 0));
    add_bits(16'b10101, 5, 1, 'b00101);
    // overlap = 0
    vecs.push_back(mk(1, 1, 8'b101, 3, 0, 0, 0, 0));
    add_bits(16'b10101, 5, 0, 'b00100);
    // valid gaps 1,_,0,_,_,1 (gap data toggled to prove it is ignored)
    vecs.push_back(mk(1, 1, 8'b101, 3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    // mid-stream reset discards partial history
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    add_bits(16'b0111, 4, 1, 0);
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
    add_bits(16'b110, 3, 1, 0);
    add_bits(16'b0111110, 7, 1, 'b0000001);
    // load with len 0 drops coincident bit, then len-1 pattern matches each bit
    vecs.push_back(mk(1, 1, 8'b1, 0, 1, 1, 0, 0));
    add_bits(16'b11, 2, 0, 'b11);
    add_bits(16'b0, 1, 0, 0);
    // oversize length clamps to 8
    vecs.push_back(mk(1, 1, 8'hA5, 15, 0, 0, 0, 0));
    add_bits(16'hA5, 8, 0, 'h01);
    // bits above len ignored: 0xFD low 3 bits = 101
    vecs.push_back(mk(1, 1, 8'hFD, 3, 0, 0, 1, 0));
    add_bits(16'b101, 3, 1, 'b001);

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].ld, vecs[k].pat, vecs[k].len,
           vecs[k].v, vecs[k].b, vecs[k].ov);
      check($sformatf("vec%0d_w", k), int'(w), int'(vecs[k].ew));
    end

    // overlap change mid-stream keeps history: pattern 11
    step(1, 1, 8'b11, 2, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0); check("ovchg_b1", int'(w), 0);
    step(1, 0, 0, 0, 1, 1, 0); check("ovchg_b2", int'(w), 1);
    step(1, 0, 0, 0, 1, 1, 0); check("ovchg_b3", int'(w), 0);
    step(1, 0, 0, 0, 1, 1, 1); check("ovchg_b4", int'(w), 1);
    step(1, 0, 0, 0, 1, 1, 1); check("ovchg_b5", int'(w), 1);

`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
    step(0, 0, 0, 0, 0, 0, 0); check("cnt_rst", int'(match_cnt), 0);
    step(1, 1, 8'b1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0); check("cnt_1", int'(match_cnt), 1);
    step(1, 0, 0, 0, 1, 1, 0); check("cnt_2", int'(match_cnt), 2);
    step(1, 0, 0, 0, 1, 1, 0); check("cnt_3", int'(match_cnt), 3);
    step(1, 0, 0, 0, 1, 1, 0); check("cnt_sat4", int'(match_cnt), 3);
    step(1, 0, 0, 0, 1, 1, 0); check("cnt_sat5", int'(match_cnt), 3);
    step(1, 1, 8'b1, 1, 0, 0, 0); check("cnt_load", int'(match_cnt), 0);
`endif

    // randomized run against the reference model
    step(0, 0, 0, 0, 0, 0, 0);
    check("rand_rst_w", int'(w), int'(m_w));
    begin
      bit ov_r = 0;
      for (int n = 0; n < 4000; n++) begin
        bit       r_r  = ($urandom_range(0, 199) != 0);
        bit       ld_r = ($urandom_range(0, 39) == 0);
        bit [7:0] p_r  = 8'($urandom);
        bit [3:0] l_r  = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                                                      : 4'($urandom_range(0, 4));
        bit       v_r  = ($urandom_range(0, 9) < 7);
        bit       b_r  = 1'($urandom);
        if ($urandom_range(0, 49) == 0) ov_r = ~ov_r;
        step(r_r, ld_r, p_r, l_r, v_r, b_r, ov_r);
        check($sformatf("rand%0d_w", n), int'(w), int'(m_w));
`ifdef PARAM_SEQ_DET_MATCH_CNT_EN
        check($sformatf("rand%0d_cnt", n), int'(match_cnt), m_cnt);
`endif
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_seq_det.md
Name: param_seq_det

Overview:
- Parametrised serial pattern detector, the successor to the fixed 7-bit flag-sequence detector.
- Detects a runtime-programmable bit pattern of 1..PAT_W bits on a serial stream qualified by a valid strobe.
- Supports an overlapping or non-overlapping match mode.
- Used on serial receive paths for flag/sync detection; w drives downstream framing logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- DEF_PAT, 8'b0011_1110, pattern loaded at reset; low DEF_LEN bits significant.
- DEF_LEN, 7, pattern length loaded at reset (1..PAT_W).
- CNT_W, 8, width of match counter (optional feature only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- serIn  in  1  serial data bit.
- serValid  in  1  serIn is sampled only when high.
- overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after a match.
- cfg_load  in  1  one-cycle strobe that loads cfg_pat and cfg_len.
- cfg_pat  in  PAT_W  new pattern; first-received bit at cfg_pat[len-1], last at cfg_pat[0].
- cfg_len  in  $clog2(PAT_W+1)  new pattern length.
- w  out  1  one-cycle match pulse.
- match_cnt  out  CNT_W  saturating match count (only with MATCH_CNT_EN).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-low.
- Internal state:
  - pat_reg[PAT_W]
  - len_reg
  - hist[PAT_W]: shift register, newest bit at hist[0]
  - fill: 0..PAT_W, number of valid history bits
- Reset (rst==0 at a rising edge):
  - pat_reg=DEF_PAT, len_reg=DEF_LEN, hist=0, fill=0, w=0, match_cnt=0.
  - Reset overrides all other inputs. Reset mid-stream discards partial history.
- Priority each edge when rst==1: cfg_load > serValid > idle.
- cfg_load=1:
  - pat_reg=cfg_pat.
  - len_reg=clamp(cfg_len): 0 is stored as 1; values >PAT_W are stored as PAT_W.
  - hist=0, fill=0, w=0.
  - A serValid bit in the same cycle is dropped.
- serValid=1 (no load):
  - nh = {hist[PAT_W-2:0], serIn}; nf = min(fill+1, PAT_W).
  - hit = (nf >= len_reg) && (nh[len_reg-1:0] == pat_reg[len_reg-1:0]).
  - hist=nh. w=hit (registered).
  - fill = (hit && !overlap) ? 0 : nf.
- serValid=0: hist and fill hold; w=0.
- Latency: w rises in the cycle after the edge that samples the final pattern bit (Moore-style, one pulse per match). No combinational path from inputs to w.
- Back-to-back matches are possible only with overlap=1, or with len_reg=1 in either mode.
- Bits of pat_reg above len_reg-1 are ignored.
- A change of overlap takes effect on the next sampled bit; history is not cleared.

Optional Feature:
- Macro: PARAM_SEQ_DET_MATCH_CNT_EN.
- Defined:
  - match_cnt increments on every hit (the same edge that sets w=1).
  - Saturates at 2^CNT_W-1.
  - Cleared by reset and by cfg_load.
- Undefined:
  - Port match_cnt and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset defaults: hold rst=0 for 2 cycles, then send 0,1,1,1,1,1,0 with serValid=1 each cycle -> w=0 through the 7th edge; w=1 for exactly one cycle after the 7th edge; w=0 afterwards.
- Overlap: cfg_load with cfg_pat=3'b101, cfg_len=3; send 1,0,1,0,1.
  - overlap=1 -> pulses after bits 3 and 5.
  - overlap=0 -> pulse after bit 3 only.
- Valid gaps: pattern 101; bits 1,_,0,_,_,1 where _ = serValid=0 -> a single w pulse after the final 1; w=0 during all gap cycles.
- Mid-stream reset: default pattern; send 0,1,1,1; rst=0 for one cycle; then 1,1,0 -> no pulse. A full 0111110 sent afterwards -> one pulse.
- cfg_load priority and clamping:
  - cfg_load with cfg_len=0, cfg_pat[0]=1, serValid=1, serIn=1 in the same cycle -> bit dropped, w=0.
  - Next bits 1,1 -> w pulses after each.
  - cfg_len > PAT_W -> behaves as length PAT_W.
- Counter (macro defined, CNT_W=2): pattern len 1 = 1'b1, send 5 ones -> match_cnt sequence 1,2,3,3,3; then cfg_load -> match_cnt=0.
